// File: rtl/voq_pkg.sv
// voq_pkg: shared helpers for the virtual-output-queue manager.
//   sel_width(n) : width of a queue selector for n queues (min 1)
//   cnt_width(d) : width of a ring pointer / occupancy count for depth d
//                  (index bits plus one wrap bit)
//   DROP_CNT_W   : width of the saturating drop counter
package voq_pkg;

  localparam int unsigned DROP_CNT_W = 16;

  function automatic int unsigned sel_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned d);
    return $clog2(d) + 1;
  endfunction

endpackage

// File: rtl/simple_dual_port_mem.sv
// simple_dual_port_mem: one write port, one registered read port, same clock.
//   clk      clock
//   wr_en    write strobe
//   wr_addr  write address
//   wr_data  write data
//   rd_en    read strobe; rd_data updates at the edge where rd_en is high
//   rd_addr  read address
//   rd_data  registered read data
// Contents are not reset.
module simple_dual_port_mem #(
  parameter int unsigned MEM_SIZE   = 1024,
  parameter int unsigned DATA_WIDTH = 32,
  localparam int unsigned AW        = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [AW-1:0]         rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [MEM_SIZE];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/voq_mgr.sv
// voq_mgr: per-ingress virtual output queue manager. EGRESS_CNT ring buffers
// of metadata share one dual-port RAM; each word is stamped with arrival time.
//   clk, reset   clock, synchronous active-high reset
//   enq_en/enq_sel/enq_meta/time_stamp   enqueue request, target queue, data, time
//   deq_en/deq_sel                       dequeue request and source queue
//   flush_en/flush_sel                   empty one queue in a single cycle
//   deq_valid/deq_meta/deq_qid           dequeued word, one cycle after acceptance
//   is_empty/is_full                     per-queue flags (from current pointers)
//   occupancy                            per-queue counts, queue q at [q*CW +: CW]
//   enq_drop/drop_cnt                    rejected-enqueue pulse and saturating count
module voq_mgr
  import voq_pkg::*;
#(
  parameter int unsigned EGRESS_CNT = 4,
  parameter int unsigned DEPTH      = 1024,
  parameter int unsigned META_WIDTH = 32,
  parameter int unsigned TS_WIDTH   = 11,
  parameter int unsigned TS_LSB     = 11
) (
  input  logic                                              clk,
  input  logic                                              reset,
  input  logic                                              enq_en,
  input  logic [sel_width(EGRESS_CNT)-1:0]                  enq_sel,
  input  logic [META_WIDTH-1:0]                             enq_meta,
  input  logic [TS_WIDTH-1:0]                               time_stamp,
  input  logic                                              deq_en,
  input  logic [sel_width(EGRESS_CNT)-1:0]                  deq_sel,
  input  logic                                              flush_en,
  input  logic [sel_width(EGRESS_CNT)-1:0]                  flush_sel,
  output logic                                              deq_valid,
  output logic [META_WIDTH-1:0]                             deq_meta,
  output logic [sel_width(EGRESS_CNT)-1:0]                  deq_qid,
  output logic [EGRESS_CNT-1:0]                             is_empty,
  output logic [EGRESS_CNT-1:0]                             is_full,
  output logic [EGRESS_CNT*cnt_width(DEPTH)-1:0]            occupancy,
  output logic                                              enq_drop,
  output logic [DROP_CNT_W-1:0]                             drop_cnt
);

  localparam int unsigned SW = sel_width(EGRESS_CNT);
  localparam int unsigned CW = cnt_width(DEPTH);
  localparam int unsigned IW = CW - 1;
  localparam int unsigned AW = SW + IW;

  // Write/read slot index of every queue, gathered for the address muxes.
  logic [EGRESS_CNT-1:0][IW-1:0] wr_idx_all;
  logic [EGRESS_CNT-1:0][IW-1:0] rd_idx_all;

  logic                  enq_flush_hit;
  logic                  deq_flush_hit;
  logic                  enq_accept;
  logic                  deq_accept;
  logic                  drop_event;
  logic [META_WIDTH-1:0] stamped_meta;
  logic [META_WIDTH-1:0] rd_data;
  logic                  deq_valid_q;

  // Acceptance is decided from the flags before the edge: no same-cycle
  // full/empty relief and no enqueue-to-dequeue bypass.
  always_comb begin
    enq_flush_hit = flush_en && (flush_sel == enq_sel);
    deq_flush_hit = flush_en && (flush_sel == deq_sel);
    enq_accept    = enq_en && !is_full[enq_sel] && !enq_flush_hit;
    deq_accept    = deq_en && !is_empty[deq_sel] && !deq_flush_hit;
    // A flush collision discards silently, so it never counts as a drop.
    drop_event    = enq_en && is_full[enq_sel] && !enq_flush_hit;
  end

  always_comb begin
    stamped_meta                        = enq_meta;
    stamped_meta[TS_LSB +: TS_WIDTH]    = time_stamp;
  end

  for (genvar q = 0; q < EGRESS_CNT; q++) begin : g_queue
    logic [CW-1:0] wr_ptr;
    logic [CW-1:0] rd_ptr;
    logic          enq_hit;
    logic          deq_hit;
    logic          flush_hit;

    assign enq_hit   = enq_accept && (enq_sel == SW'(q));
    assign deq_hit   = deq_accept && (deq_sel == SW'(q));
    assign flush_hit = flush_en && (flush_sel == SW'(q));

    always_ff @(posedge clk) begin
      if (reset) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else if (flush_hit) begin
        rd_ptr <= wr_ptr;
      end else begin
        if (enq_hit) begin
          wr_ptr <= wr_ptr + CW'(1);
        end
        if (deq_hit) begin
          rd_ptr <= rd_ptr + CW'(1);
        end
      end
    end

    // The extra wrap bit distinguishes full from empty, so all DEPTH slots
    // are usable.
    assign is_empty[q]              = (wr_ptr == rd_ptr);
    assign is_full[q]               = (wr_ptr[IW-1:0] == rd_ptr[IW-1:0]) &&
                                      (wr_ptr[CW-1] != rd_ptr[CW-1]);
    assign occupancy[q*CW +: CW]    = wr_ptr - rd_ptr;
    assign wr_idx_all[q]            = wr_ptr[IW-1:0];
    assign rd_idx_all[q]            = rd_ptr[IW-1:0];
  end

  simple_dual_port_mem #(
    .MEM_SIZE  (EGRESS_CNT * DEPTH),
    .DATA_WIDTH(META_WIDTH)
  ) u_mem (
    .clk    (clk),
    .wr_en  (enq_accept),
    .wr_addr(AW'({enq_sel, wr_idx_all[enq_sel]})),
    .wr_data(stamped_meta),
    .rd_en  (deq_accept),
    .rd_addr(AW'({deq_sel, rd_idx_all[deq_sel]})),
    .rd_data(rd_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      deq_valid_q <= 1'b0;
      deq_qid     <= '0;
      enq_drop    <= 1'b0;
      drop_cnt    <= '0;
    end else begin
      deq_valid_q <= deq_accept;
      if (deq_accept) begin
        deq_qid <= deq_sel;
      end
      enq_drop <= drop_event;
      if (drop_event && (drop_cnt != '1)) begin
        drop_cnt <= drop_cnt + DROP_CNT_W'(1);
      end
    end
  end

  // RAM read data is held between reads; gate it so idle cycles show zero.
  assign deq_valid = deq_valid_q;
  assign deq_meta  = deq_valid_q ? rd_data : '0;

endmodule

// File: tb/tb_voq_mgr.sv
// tb_voq_mgr: directed, table-driven bench for voq_mgr (4 queues, DEPTH 8).
module tb_voq_mgr;

  localparam int unsigned EC  = 4;
  localparam int unsigned DEP = 8;
  localparam int unsigned CW  = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        enq_en;
  logic [1:0]  enq_sel;
  logic [31:0] enq_meta;
  logic [10:0] time_stamp;
  logic        deq_en;
  logic [1:0]  deq_sel;
  logic        flush_en;
  logic [1:0]  flush_sel;
  logic        deq_valid;
  logic [31:0] deq_meta;
  logic [1:0]  deq_qid;
  logic [3:0]  is_empty;
  logic [3:0]  is_full;
  logic [15:0] occupancy;
  logic        enq_drop;
  logic [15:0] drop_cnt;

  voq_mgr #(
    .EGRESS_CNT(EC),
    .DEPTH     (DEP),
    .META_WIDTH(32),
    .TS_WIDTH  (11),
    .TS_LSB    (11)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enq_en    (enq_en),
    .enq_sel   (enq_sel),
    .enq_meta  (enq_meta),
    .time_stamp(time_stamp),
    .deq_en    (deq_en),
    .deq_sel   (deq_sel),
    .flush_en  (flush_en),
    .flush_sel (flush_sel),
    .deq_valid (deq_valid),
    .deq_meta  (deq_meta),
    .deq_qid   (deq_qid),
    .is_empty  (is_empty),
    .is_full   (is_full),
    .occupancy (occupancy),
    .enq_drop  (enq_drop),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        enq_en;
    logic [1:0]  enq_sel;
    logic [31:0] enq_meta;
    logic [10:0] ts;
    logic        deq_en;
    logic [1:0]  deq_sel;
    logic        flush_en;
    logic [1:0]  flush_sel;
    logic        exp_dv;
    logic [31:0] exp_meta;
    logic [1:0]  exp_qid;
    int unsigned exp_occ [4];
    logic        exp_drop;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t vecs [$];

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [31:0] stamp(input logic [31:0] meta, input logic [10:0] ts);
    logic [31:0] mask;
    mask = 32'h7FF << 11;
    return (meta & ~mask) | ({21'd0, ts} << 11);
  endfunction

  function automatic logic [15:0] occ_vec(input int unsigned o0, input int unsigned o1,
                                          input int unsigned o2, input int unsigned o3);
    return {o3[3:0], o2[3:0], o1[3:0], o0[3:0]};
  endfunction

  task automatic add_vec(input logic ee, input logic [1:0] es, input logic [31:0] em,
                         input logic [10:0] ts, input logic de, input logic [1:0] ds,
                         input logic fe, input logic [1:0] fs, input logic dv,
                         input logic [31:0] dm, input logic [1:0] dq,
                         input int unsigned o0, input int unsigned o1,
                         input int unsigned o2, input int unsigned o3,
                         input logic drp, input logic [15:0] cnt);
    vec_t v;
    v.enq_en = ee; v.enq_sel = es; v.enq_meta = em; v.ts = ts;
    v.deq_en = de; v.deq_sel = ds; v.flush_en = fe; v.flush_sel = fs;
    v.exp_dv = dv; v.exp_meta = dm; v.exp_qid = dq;
    v.exp_occ[0] = o0; v.exp_occ[1] = o1; v.exp_occ[2] = o2; v.exp_occ[3] = o3;
    v.exp_drop = drp; v.exp_cnt = cnt;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic ee, input logic [1:0] es, input logic [31:0] em,
                       input logic [10:0] ts, input logic de, input logic [1:0] ds,
                       input logic fe, input logic [1:0] fs);
    enq_en = ee; enq_sel = es; enq_meta = em; time_stamp = ts;
    deq_en = de; deq_sel = ds; flush_en = fe; flush_sel = fs;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_occ"},   {16'd0, occupancy}, 32'd0);
    check({tag, "_empty"}, {28'd0, is_empty},  32'hF);
    check({tag, "_full"},  {28'd0, is_full},   32'h0);
    check({tag, "_dv"},    {31'd0, deq_valid}, 32'd0);
    check({tag, "_meta"},  deq_meta,           32'd0);
    check({tag, "_qid"},   {30'd0, deq_qid},   32'd0);
    check({tag, "_drop"},  {31'd0, enq_drop},  32'd0);
    check({tag, "_cnt"},   {16'd0, drop_cnt},  32'd0);
  endtask

  initial begin
    logic [31:0] mq [$];
    logic [31:0] popped;
    logic [31:0] m;
    logic [10:0] t;
    logic [15:0] exp_cnt;
    logic        acc_enq, acc_deq, do_enq, do_deq;
    int unsigned enq_done;
    logic [3:0]  emp, ful;

    // ---------------- vector table ----------------
    // single enqueue/dequeue on queue 2
    add_vec(1, 2, 32'hFFFF_FFFF, 11'h2AA, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    add_vec(0, 0, 0, 0, 1, 2, 0, 0, 1, 32'hFFD5_57FF, 2, 0, 0, 0, 0, 0, 0);
    add_vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add_vec(0, 0, 0, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);   // empty: ignored
    // fill queue 0, then one over
    for (int i = 0; i < 8; i++)
      add_vec(1, 0, 32'h100 + i, 0, 0, 0, 0, 0, 0, 0, 0, i + 1, 0, 0, 0, 0, 0);
    add_vec(1, 0, 32'h1FF, 0, 0, 0, 0, 0, 0, 0, 0, 8, 0, 0, 0, 1, 1);
    add_vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8, 0, 0, 0, 0, 1);
    for (int k = 0; k < 8; k++)
      add_vec(0, 0, 0, 0, 1, 0, 0, 0, 1, 32'h100 + k, 0, 7 - k, 0, 0, 0, 0, 1);
    // simultaneous enqueue/dequeue
    add_vec(1, 0, 32'h200, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1);  // empty: no bypass
    add_vec(1, 0, 32'h201, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0, 1);
    add_vec(1, 0, 32'h202, 0, 1, 0, 0, 0, 1, 32'h200, 0, 2, 0, 0, 0, 0, 1);
    for (int j = 0; j < 6; j++)
      add_vec(1, 0, 32'h203 + j, 0, 0, 0, 0, 0, 0, 0, 0, 3 + j, 0, 0, 0, 0, 1);
    add_vec(1, 0, 32'h209, 0, 1, 0, 0, 0, 1, 32'h201, 0, 7, 0, 0, 0, 1, 2); // full
    // flush
    add_vec(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2);
    for (int i = 0; i < 5; i++)
      add_vec(1, 1, 32'h300 + i, 0, 0, 0, 0, 0, 0, 0, 0, 0, i + 1, 0, 0, 0, 2);
    for (int i = 0; i < 2; i++)
      add_vec(1, 0, 32'h400 + i, 0, 0, 0, 0, 0, 0, 0, 0, i + 1, 5, 0, 0, 0, 2);
    add_vec(1, 1, 32'h3FF, 0, 0, 0, 1, 1, 0, 0, 0, 2, 0, 0, 0, 0, 2);
    add_vec(0, 0, 0, 0, 1, 0, 0, 0, 1, 32'h400, 0, 1, 0, 0, 0, 0, 2);
    add_vec(0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2);      // flush beats deq
    add_vec(1, 1, 32'h500, 11'h7FF, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 2);
    add_vec(1, 2, 32'h600, 11'h001, 1, 1, 0, 0, 1, 32'h003F_FD00, 1, 0, 0, 1, 0, 0, 2);
    add_vec(0, 0, 0, 0, 1, 2, 0, 0, 1, 32'h0000_0E00, 2, 0, 0, 0, 0, 0, 2);

    // ---------------- reset ----------------
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    tick();
    tick();
    check_reset_state("reset");
    reset = 1'b0;

    // ---------------- table ----------------
    foreach (vecs[i]) begin
      drive(vecs[i].enq_en, vecs[i].enq_sel, vecs[i].enq_meta, vecs[i].ts,
            vecs[i].deq_en, vecs[i].deq_sel, vecs[i].flush_en, vecs[i].flush_sel);
      tick();
      for (int q = 0; q < 4; q++) begin
        emp[q] = (vecs[i].exp_occ[q] == 0);
        ful[q] = (vecs[i].exp_occ[q] == DEP);
      end
      check($sformatf("v%0d_dv", i), {31'd0, deq_valid}, {31'd0, vecs[i].exp_dv});
      check($sformatf("v%0d_meta", i), deq_meta, vecs[i].exp_meta);
      if (vecs[i].exp_dv)
        check($sformatf("v%0d_qid", i), {30'd0, deq_qid}, {30'd0, vecs[i].exp_qid});
      check($sformatf("v%0d_occ", i), {16'd0, occupancy},
            {16'd0, occ_vec(vecs[i].exp_occ[0], vecs[i].exp_occ[1],
                            vecs[i].exp_occ[2], vecs[i].exp_occ[3])});
      check($sformatf("v%0d_empty", i), {28'd0, is_empty}, {28'd0, emp});
      check($sformatf("v%0d_full", i), {28'd0, is_full}, {28'd0, ful});
      check($sformatf("v%0d_drop", i), {31'd0, enq_drop}, {31'd0, vecs[i].exp_drop});
      check($sformatf("v%0d_cnt", i), {16'd0, drop_cnt}, {16'd0, vecs[i].exp_cnt});
    end

    // ---------------- wrap-around on queue 3 ----------------
    exp_cnt  = 16'd2;
    enq_done = 0;
    for (int i = 0; i < 100 && (enq_done < 20 || mq.size() > 0); i++) begin
      do_enq  = (enq_done < 20);
      do_deq  = (i % 2 == 1) || (enq_done >= 20);
      acc_enq = do_enq && (mq.size() < DEP);
      acc_deq = do_deq && (mq.size() > 0);
      m = $urandom;
      t = 11'((i * 37) & 32'h7FF);
      drive(do_enq, 3, m, t, do_deq, 3, 0, 0);
      popped = 32'd0;
      if (acc_deq) popped = mq.pop_front();
      if (acc_enq) begin
        mq.push_back(stamp(m, t));
        enq_done++;
      end
      if (do_enq && !acc_enq) exp_cnt = exp_cnt + 16'd1;
      tick();
      check($sformatf("wrap%0d_dv", i), {31'd0, deq_valid}, {31'd0, acc_deq});
      check($sformatf("wrap%0d_meta", i), deq_meta, popped);
      check($sformatf("wrap%0d_occ", i), {16'd0, occupancy},
            {16'd0, occ_vec(0, 0, 0, mq.size())});
      check($sformatf("wrap%0d_empty", i), {31'd0, is_empty[3]}, {31'd0, mq.size() == 0});
      check($sformatf("wrap%0d_full", i), {31'd0, is_full[3]}, {31'd0, mq.size() == DEP});
      check($sformatf("wrap%0d_drop", i), {31'd0, enq_drop}, {31'd0, do_enq && !acc_enq});
      check($sformatf("wrap%0d_cnt", i), {16'd0, drop_cnt}, {16'd0, exp_cnt});
    end
    check("wrap_done", enq_done, 32'd20);

    // ---------------- drop counter saturation ----------------
    drive(0, 0, 0, 0, 0, 0, 1, 3);
    tick();
    for (int i = 0; i < 8; i++) begin
      drive(1, 3, 32'h700 + i, 0, 0, 0, 0, 0);
      tick();
    end
    check("sat_full", {28'd0, is_full}, 32'h8);
    drive(1, 3, 32'hDEAD, 0, 0, 0, 0, 0);
    for (int i = 0; i < 70000; i++) tick();
    check("sat_cnt", {16'd0, drop_cnt}, 32'hFFFF);
    check("sat_drop", {31'd0, enq_drop}, 32'd1);
    check("sat_occ", {16'd0, occupancy}, {16'd0, occ_vec(0, 0, 0, 8)});

    // ---------------- reset during a dequeue ----------------
    drive(0, 0, 0, 0, 1, 3, 0, 0);
    reset = 1'b1;
    tick();
    check_reset_state("midrst");
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    check("post_rst_dv", {31'd0, deq_valid}, 32'd0);
    check("post_rst_occ", {16'd0, occupancy}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
